// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with registered read, read-valid strobe and
// a clear engine that zeroes the whole array after reset and on request.
// Ports: clk, rst_n (async, active-low), e/w/r command, addr, din,
//   wstrb (only with RAM_WSTRB_EN), clr, dout, dvalid, busy.
// Optional byte-lane write strobes are enabled by the macro RAM_WSTRB_EN.
module ram_sp_clr #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          e,
   input  logic          w,
   input  logic          r,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
`ifdef RAM_WSTRB_EN
   input  logic [DW/8-1:0] wstrb,
`endif
   input  logic          clr,
   output logic [DW-1:0] dout,
   output logic          dvalid,
   output logic          busy
);

   localparam int DEPTH = 2**AW;

   typedef enum logic {
      READY = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t        state_q, state_n;
   logic [AW-1:0] ccnt_q, ccnt_n;

   logic [DW-1:0] mem [DEPTH];

   logic          we;
   logic          rd;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd;
`ifdef RAM_WSTRB_EN
   logic [DW/8-1:0] wbe;
`endif

   // Commands only reach the array in READY, and clr pre-empts them.
   logic cmd_ok;
   assign cmd_ok = (state_q == READY) && e && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         ccnt_q  <= '0;
      end else begin
         state_q <= state_n;
         ccnt_q  <= ccnt_n;
      end
   end

   always_comb begin
      state_n = state_q;
      ccnt_n  = '0;
      we      = 1'b0;
      rd      = 1'b0;
      wa      = addr;
      wd      = din;
`ifdef RAM_WSTRB_EN
      wbe     = wstrb;
`endif
      unique case (state_q)
         CLEAR: begin
            // Sweep writes full zero words regardless of strobes.
            we     = 1'b1;
            wa     = ccnt_q;
            wd     = '0;
`ifdef RAM_WSTRB_EN
            wbe    = '1;
`endif
            ccnt_n = ccnt_q + 1'b1;
            if (ccnt_q == {AW{1'b1}}) begin
               state_n = READY;
               ccnt_n  = '0;
            end
         end
         READY: begin
            we = cmd_ok && w;
            rd = cmd_ok && r;
            if (clr) begin
               state_n = CLEAR;
            end
         end
         default: begin
            state_n = CLEAR;
         end
      endcase
   end

   // Array has no reset; the clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (we) begin
`ifdef RAM_WSTRB_EN
         for (int k = 0; k < DW/8; k++) begin
            if (wbe[k]) begin
               mem[wa][8*k +: 8] <= wd[8*k +: 8];
            end
         end
`else
         mem[wa] <= wd;
`endif
      end
   end

   // Read-first: the array write above lands after this sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout   <= '0;
         dvalid <= 1'b0;
      end else begin
         dvalid <= rd;
         if (rd) begin
            dout <= mem[addr];
         end
      end
   end

   assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed self-checking bench for ram_sp_clr (DW=16, AW=3).
// Inputs change on falling edges; outputs are checked on falling edges.
module tb_ram_sp_clr;

   logic        clk;
   logic        rst_n;
   logic        e;
   logic        w;
   logic        r;
   logic [2:0]  addr;
   logic [15:0] din;
`ifdef RAM_WSTRB_EN
   logic [1:0]  wstrb;
`endif
   logic        clr;
   logic [15:0] dout;
   logic        dvalid;
   logic        busy;

   int cmp;
   int err;

   ram_sp_clr #(.DW(16), .AW(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .e      (e),
      .w      (w),
      .r      (r),
      .addr   (addr),
      .din    (din),
`ifdef RAM_WSTRB_EN
      .wstrb  (wstrb),
`endif
      .clr    (clr),
      .dout   (dout),
      .dvalid (dvalid),
      .busy   (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive(input logic ie, input logic iw,
                        input logic ir, input logic [2:0] ia,
                        input logic [15:0] id, input logic ic);
      e    = ie;
      w    = iw;
      r    = ir;
      addr = ia;
      din  = id;
      clr  = ic;
`ifdef RAM_WSTRB_EN
      wstrb = 2'b11;
`endif
   endtask

   task automatic wait_sweep(input string tag);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         cmp++;
         if (busy !== (i < 8)) begin
            err++;
            $display("FAIL %s busy edge %0d: got %b want %b",
                     tag, i, busy, (i < 8));
         end
         cmp++;
         if (dvalid !== 1'b0) begin
            err++;
            $display("FAIL %s dvalid edge %0d: got %b want 0",
                     tag, i, dvalid);
         end
      end
   endtask

   task automatic read_zeros(input string tag);
      for (int a = 0; a < 8; a++) begin
         drive(1, 0, 1, 3'(a), 16'h0, 0);
         @(negedge clk);
         cmp++;
         if (dout !== 16'h0000 || dvalid !== 1'b1) begin
            err++;
            $display("FAIL %s addr %0d: got %h/%b want 0000/1",
                     tag, a, dout, dvalid);
         end
      end
      drive(0, 0, 0, 3'd0, 16'h0, 0);
      @(negedge clk);
      cmp++;
      if (dvalid !== 1'b0) begin
         err++;
         $display("FAIL %s idle dvalid: got %b want 0", tag, dvalid);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive(0, 0, 0, 3'd0, 16'h0, 0);
      #13;
      cmp++;
      if (busy !== 1'b1 || dvalid !== 1'b0 || dout !== 16'h0) begin
         err++;
         $display("FAIL reset_state: got b=%b v=%b d=%h want 1/0/0000",
                  busy, dvalid, dout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_sweep("reset_sweep");
      read_zeros("reset_read");
   endtask

   task automatic test_back_to_back;
      for (int a = 0; a < 8; a++) begin
         drive(1, 1, 0, 3'(a), 16'(a + 1), 0);
         @(negedge clk);
      end
      for (int a = 0; a < 8; a++) begin
         drive(1, 0, 1, 3'(a), 16'h0, 0);
         @(negedge clk);
         cmp++;
         if (dout !== 16'(a + 1) || dvalid !== 1'b1) begin
            err++;
            $display("FAIL b2b_read addr %0d: got %h/%b want %h/1",
                     a, dout, dvalid, 16'(a + 1));
         end
      end
      drive(0, 0, 0, 3'd0, 16'h0, 0);
      @(negedge clk);
   endtask

   task automatic test_read_first;
      drive(1, 1, 1, 3'd2, 16'hAAAA, 0);
      @(negedge clk);
      cmp++;
      if (dout !== 16'h0003 || dvalid !== 1'b1) begin
         err++;
         $display("FAIL rf_old: got %h/%b want 0003/1", dout, dvalid);
      end
      drive(1, 0, 1, 3'd2, 16'h0, 0);
      @(negedge clk);
      cmp++;
      if (dout !== 16'hAAAA) begin
         err++;
         $display("FAIL rf_new: got %h want aaaa", dout);
      end
      drive(0, 1, 0, 3'd2, 16'h5555, 0);
      @(negedge clk);
      cmp++;
      if (dvalid !== 1'b0 || dout !== 16'hAAAA) begin
         err++;
         $display("FAIL e0_hold: got %h/%b want aaaa/0", dout, dvalid);
      end
      drive(1, 0, 1, 3'd2, 16'h0, 0);
      @(negedge clk);
      cmp++;
      if (dout !== 16'hAAAA) begin
         err++;
         $display("FAIL e0_nowrite: got %h want aaaa", dout);
      end
      drive(0, 0, 0, 3'd0, 16'h0, 0);
      @(negedge clk);
   endtask

   task automatic test_clear;
      drive(1, 1, 0, 3'd0, 16'h5555, 1);
      @(negedge clk);
      cmp++;
      if (busy !== 1'b1 || dvalid !== 1'b0) begin
         err++;
         $display("FAIL clr_start: got b=%b v=%b want 1/0",
                  busy, dvalid);
      end
      drive(1, 1, 0, 3'd1, 16'h7777, 0);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         cmp++;
         if (busy !== (i < 8) || dvalid !== 1'b0) begin
            err++;
            $display("FAIL clr_busy edge %0d: got b=%b v=%b want %b/0",
                     i, busy, dvalid, (i < 8));
         end
         if (i == 1) drive(1, 0, 1, 3'd1, 16'h0, 0);
         else if (i == 7) drive(1, 1, 0, 3'd0, 16'h7777, 0);
         else drive(0, 0, 0, 3'd0, 16'h0, 0);
      end
      read_zeros("clr_read");
   endtask

   task automatic test_reset_mid_clear;
      drive(1, 1, 0, 3'd5, 16'hBEEF, 0);
      @(negedge clk);
      drive(1, 0, 1, 3'd5, 16'h0, 0);
      @(negedge clk);
      cmp++;
      if (dout !== 16'hBEEF) begin
         err++;
         $display("FAIL pre_rst_read: got %h want beef", dout);
      end
      drive(0, 0, 0, 3'd0, 16'h0, 1);
      @(negedge clk);
      drive(0, 0, 0, 3'd0, 16'h0, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      cmp++;
      if (dout !== 16'h0 || busy !== 1'b1 || dvalid !== 1'b0) begin
         err++;
         $display("FAIL mid_rst: got d=%h b=%b v=%b want 0000/1/0",
                  dout, busy, dvalid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_sweep("rst2_sweep");
      read_zeros("rst2_read");
   endtask

`ifdef RAM_WSTRB_EN
   task automatic test_wstrb;
      drive(1, 1, 0, 3'd4, 16'hFFFF, 0);
      @(negedge clk);
      drive(1, 1, 0, 3'd4, 16'h1234, 0);
      wstrb = 2'b01;
      @(negedge clk);
      drive(1, 0, 1, 3'd4, 16'h0, 0);
      @(negedge clk);
      cmp++;
      if (dout !== 16'hFF34) begin
         err++;
         $display("FAIL wstrb01: got %h want ff34", dout);
      end
      drive(1, 1, 0, 3'd4, 16'h0000, 0);
      wstrb = 2'b00;
      @(negedge clk);
      drive(1, 0, 1, 3'd4, 16'h0, 0);
      @(negedge clk);
      cmp++;
      if (dout !== 16'hFF34) begin
         err++;
         $display("FAIL wstrb00: got %h want ff34", dout);
      end
      drive(0, 0, 0, 3'd0, 16'h0, 0);
      @(negedge clk);
   endtask
`endif

   initial begin
      cmp = 0;
      err = 0;
      test_reset();
      test_back_to_back();
      test_read_first();
      test_clear();
      test_reset_mid_clear();
`ifdef RAM_WSTRB_EN
      test_wstrb();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmp, err);
      $finish;
   end

endmodule

// File: doc/ram_sp_clr.md
# ram_sp_clr

Parametrised single-port synchronous RAM with a registered read port, a read-valid strobe, and a hardware clear engine. The clear engine zeroes every location after reset and on request. It supersedes the fixed 8x16 RAM as the general storage primitive for datapath and register-file style buffers. It is driven directly by a controller FSM through a simple enable/write/read command interface.

## Interface

Parameters:
- DW, 16, data word width in bits; must be a multiple of 8 when RAM_WSTRB_EN is defined.
- AW, 3, address width; depth is 2**AW words.

Ports:
- clk  input  1  rising-edge clock; the block has one clock.
- rst_n  input  1  asynchronous, active-low reset.
- e  input  1  command enable; when low, w and r are ignored.
- w  input  1  write request, qualified by e.
- r  input  1  read request, qualified by e.
- addr  input  AW  word address.
- din  input  DW  write data.
- wstrb  input  DW/8  byte-lane write strobes; present only with RAM_WSTRB_EN.
- clr  input  1  single-cycle request to zero the whole array.
- dout  output  DW  registered read data.
- dvalid  output  1  high for one cycle when dout carries fresh read data.
- busy  output  1  high while the clear engine is running; commands are dropped.

## Operation

- FSM has two states, CLEAR and READY. A clear counter ccnt[AW-1:0] is internal.
- Reset (rst_n low, asynchronous):
  - State goes to CLEAR and ccnt goes to 0.
  - dout = 0, dvalid = 0, busy = 1.
  - Array contents are not reset directly; the clear sweep zeroes them.
- CLEAR:
  - Each cycle writes 0 to mem[ccnt], then increments ccnt.
  - When ccnt = 2**AW-1 is written, the next state is READY and ccnt returns to 0.
  - busy = 1 for the whole state.
  - e, w, r and clr are ignored. No array access from the command port takes place, and dvalid stays 0.
- READY (busy = 0):
  - e & w: mem[addr] <= din on the rising edge.
  - e & r: dout <= mem[addr] on the rising edge, and dvalid = 1 for the following cycle.
  - e & w & r at the same address: read-first. dout returns the pre-write contents, and the write still commits.
  - e = 0: no access. dout holds its last value and dvalid = 0.
  - A cycle with no read sets dvalid = 0. dout always holds the last read value.
  - clr = 1: next state is CLEAR. Any write or read in the same cycle is dropped (clr wins), and dvalid = 0 next cycle.
- Address space is exactly 2**AW words, so there is no out-of-range case.
- Reset asserted mid-clear or mid-access aborts the operation; the sweep restarts from address 0.

## Timing

- Read latency is 1 cycle. A request sampled at edge N drives dout/dvalid valid after edge N; they are sampled by the consumer at edge N+1.
- Write latency is 1 cycle. Data written at edge N is visible to a read sampled at edge N+1.
- Throughput is one command per cycle, with back-to-back reads and writes and no bubbles.
- Clear duration is exactly 2**AW cycles:
  - After rst_n rises, busy is high for the first 2**AW rising edges.
  - busy falls after the 2**AW-th edge.
  - The first command is accepted on the next edge.
- clr accepted at edge N: busy = 1 from after edge N. The 2**AW sweep cycles follow, and busy = 0 after edge N+2**AW.
- busy and dvalid are registered outputs, with no combinational path from inputs.

## Configuration

- Macro: RAM_WSTRB_EN.
- Defined:
  - The wstrb port exists.
  - A write updates only the bytes din[8k+7:8k] whose wstrb[k] = 1, and the other bytes keep their value.
  - wstrb = 0 with e & w is a no-op write.
  - The clear sweep ignores wstrb and zeroes full words.
- Undefined:
  - The wstrb port is absent, and every write updates the full word.

## Test plan

- Reset release with AW=3 -> busy = 1 for exactly 8 edges, then 0; reading addr 0..7 returns 0x0000 each, with dvalid one cycle after each request.
- Write 1..8 to addr 0..7 back-to-back, then read addr 0..7 back-to-back -> dout = 1..8 in order, dvalid high on 8 consecutive cycles, no bubbles.
- addr 2 holds 0x0003; apply e=w=r=1, addr=2, din=0xAAAA -> dout = 0x0003; the next read of addr 2 -> 0xAAAA. With e=0, w=1, din=0x5555 at addr 2 -> contents stay 0xAAAA.
- After loading data, pulse clr together with a write (addr 0, 0x5555); during busy, issue a write (addr 1, 0x7777) and a read. Required response:
  - The clr-cycle write is dropped.
  - Busy lasts 8 cycles, the busy-cycle write is dropped, and dvalid stays 0.
  - All addresses then read 0x0000.
- Drop rst_n at cycle 3 of a clear sweep -> outputs reset immediately; after release, busy lasts a full 8 edges and all addresses read 0.
- With RAM_WSTRB_EN: addr 4 = 0xFFFF, write din=0x1234 with wstrb=2'b01 -> read 0xFF34; then write wstrb=2'b00 -> still 0xFF34.
